// File: rtl/ux607_qspi_media_mcs_if.sv
// Link-side frame requests and phy-side op stream of the QSPI media layer.
// The design connects through the slave modport; the requester/phy side uses master.
interface ux607_qspi_media_mcs_if #(
    parameter int unsigned DLY_W = 8
);
    logic             link_tx_valid;
    logic             link_tx_ready;
    logic [7:0]       link_tx_bits;
    logic [DLY_W-1:0] link_cnt;
    logic             link_cs_set;
    logic             link_cs_clear;
    logic             link_cs_hold;
    logic             link_active;

    logic             op_valid;
    logic             op_ready;
    logic             op_fn;
    logic             op_stb;
    logic [DLY_W-1:0] op_cnt;
    logic [7:0]       op_data;

    modport slave (
        input  link_tx_valid, link_tx_bits, link_cnt, link_cs_set, link_cs_clear,
               link_cs_hold, op_ready,
        output link_tx_ready, link_active, op_valid, op_fn, op_stb, op_cnt, op_data
    );

    modport master (
        output link_tx_valid, link_tx_bits, link_cnt, link_cs_set, link_cs_clear,
               link_cs_hold, op_ready,
        input  link_tx_ready, link_active, op_valid, op_fn, op_stb, op_cnt, op_data
    );
endinterface

// File: rtl/ux607_qspi_media_mcs.sv
// QSPI media layer: turns link frame requests into CS-assert, transfer and
// delay ops for the phy, with an idle timeout that releases CS on its own.
module ux607_qspi_media_mcs #(
    parameter int unsigned CS_WIDTH = 4,
    parameter int unsigned CS_ID_W  = 2,
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned TO_W     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CS_ID_W-1:0]  ctrl_cs_id,
    input  logic [CS_WIDTH-1:0] ctrl_cs_dflt,
    input  logic [DLY_W-1:0]    ctrl_dla_cssck,
    input  logic [DLY_W-1:0]    ctrl_dla_sckcs,
    input  logic [DLY_W-1:0]    ctrl_dla_intercs,
    input  logic [DLY_W-1:0]    ctrl_dla_interxfr,
    input  logic [TO_W-1:0]     ctrl_cs_idle_to,
    ux607_qspi_media_mcs_if.slave bus,
    output logic                sts_timeout,
    output logic [CS_WIDTH-1:0] port_cs
);
    typedef enum logic [1:0] {
        ST_MAIN  = 2'd0,
        ST_XFR   = 2'd1,
        ST_CSOFF = 2'd2
    } state_t;

    state_t              state_q;
    logic [CS_WIDTH-1:0] port_cs_q;
    logic                cs_assert_q;
    logic                clear_q;
    logic [CS_ID_W-1:0]  cs_id_q;
    logic                cs_set_q;
    logic [TO_W-1:0]     idle_cnt_q;
    logic                to_flag_q;
    logic                sts_q;

    logic [CS_WIDTH-1:0] cs_next;
    logic [CS_WIDTH-1:0] cs_release;
    logic                cs_update;
    logic                clear_d;
    logic                cs_deassert;
    logic                idle_cycle;
    logic                to_fire;

    // An out-of-range id shifts the set bit out, leaving every line at default.
    assign cs_next     = ctrl_cs_dflt ^ (CS_WIDTH'(bus.link_cs_set) << ctrl_cs_id);
    assign cs_release  = port_cs_q ^ (CS_WIDTH'(cs_set_q) << cs_id_q);
    assign cs_update   = (cs_next != port_cs_q);
    // A clear request in the same cycle as a new frame already wins over it.
    assign clear_d     = clear_q | (bus.link_cs_clear & cs_assert_q);
    assign cs_deassert = clear_d | (cs_update & ~bus.link_cs_hold) | to_flag_q;

    assign idle_cycle  = (state_q == ST_MAIN) & cs_assert_q & ~bus.link_tx_valid
                       & (ctrl_cs_idle_to != '0);
    assign to_fire     = idle_cycle & ~to_flag_q
                       & (idle_cnt_q == (ctrl_cs_idle_to - TO_W'(1)));

    assign port_cs          = port_cs_q;
    assign sts_timeout      = sts_q;
    assign bus.link_active  = cs_assert_q;
    assign bus.op_data      = bus.link_tx_bits;

    // Op presented to the phy; op_valid never depends on op_ready.
    always_comb begin
        bus.op_valid      = 1'b0;
        bus.op_fn         = 1'b0;
        bus.op_stb        = 1'b0;
        bus.op_cnt        = '0;
        bus.link_tx_ready = 1'b0;
        unique case (state_q)
            ST_MAIN: begin
                if (!cs_assert_q) begin
                    if (bus.link_tx_valid) begin
                        bus.op_valid = 1'b1;
                        bus.op_fn    = 1'b1;
                        bus.op_cnt   = ctrl_dla_cssck;
                    end
                end else if (cs_deassert) begin
                    bus.op_valid = 1'b1;
                    bus.op_fn    = 1'b1;
                    bus.op_cnt   = ctrl_dla_sckcs;
                end else begin
                    bus.op_valid      = bus.link_tx_valid;
                    bus.op_cnt        = bus.link_cnt;
                    bus.link_tx_ready = bus.op_ready;
                end
            end
            ST_XFR: begin
                bus.op_valid = (ctrl_dla_interxfr != '0);
                bus.op_fn    = 1'b1;
                bus.op_cnt   = ctrl_dla_interxfr;
            end
            ST_CSOFF: begin
                bus.op_valid = 1'b1;
                bus.op_fn    = 1'b1;
                bus.op_stb   = 1'b1;
                bus.op_cnt   = ctrl_dla_intercs;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_MAIN;
            port_cs_q   <= '1;
            cs_assert_q <= 1'b0;
            clear_q     <= 1'b0;
            cs_id_q     <= '0;
            cs_set_q    <= 1'b0;
            idle_cnt_q  <= '0;
            to_flag_q   <= 1'b0;
            sts_q       <= 1'b0;
        end else begin
            sts_q   <= 1'b0;
            clear_q <= clear_d;
            unique case (state_q)
                ST_MAIN: begin
                    if (!cs_assert_q) begin
                        cs_id_q <= ctrl_cs_id;
                        if (!bus.link_tx_valid) begin
                            port_cs_q <= ctrl_cs_dflt;
                        end else if (bus.op_ready) begin
                            cs_assert_q <= 1'b1;
                            cs_set_q    <= bus.link_cs_set;
                            port_cs_q   <= cs_next;
                            idle_cnt_q  <= '0;
                        end
                    end else begin
                        if (cs_deassert) begin
                            if (bus.op_ready) state_q <= ST_CSOFF;
                        end else if (bus.link_tx_valid && bus.op_ready) begin
                            state_q <= ST_XFR;
                        end
                        if (bus.link_tx_valid) begin
                            idle_cnt_q <= '0;
                        end else if (idle_cycle && idle_cnt_q != '1) begin
                            idle_cnt_q <= idle_cnt_q + TO_W'(1);
                        end
                        if (to_fire) begin
                            to_flag_q <= 1'b1;
                            sts_q     <= 1'b1;
                        end
                    end
                end
                ST_XFR: begin
                    if (ctrl_dla_interxfr == '0 || bus.op_ready) state_q <= ST_MAIN;
                end
                ST_CSOFF: begin
                    if (bus.op_ready) begin
                        port_cs_q   <= cs_release;
                        cs_assert_q <= 1'b0;
                        clear_q     <= 1'b0;
                        to_flag_q   <= 1'b0;
                        state_q     <= ST_MAIN;
                    end
                end
                default: state_q <= ST_MAIN;
            endcase
        end
    end
endmodule
